conv_param: RTL and testbench
=============================

CONV_PARAM -- requirements
Module: conv_param

Interface
REQ-001 SHALL have parameter N, 16, input vector length in words.
REQ-002 SHALL have parameter M, 4, filter tap count; legal range 2 <= M <= N.
REQ-003 SHALL have parameter T, 20, data/weight/result width in bits, two's complement.
REQ-004 SHALL have parameter P, 1, number of parallel MAC lanes; legal only when P divides N-M+1.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port x_data  input  T  input vector word, signed.
REQ-008 SHALL have ports x_valid input 1 and x_ready output 1, input vector handshake.
REQ-009 SHALL have port w_data  input  T  filter weight word, signed.
REQ-010 SHALL have ports w_valid input 1 and w_ready output 1, weight handshake.
REQ-011 SHALL have port y_data  output  T  convolution result, signed.
REQ-012 SHALL have ports y_valid output 1 and y_ready input 1, output handshake.

Function
REQ-013 SHALL compute y[k] = sum over j=0..M-1 of x[k+j]*f[j], for k=0..N-M, emitted in ascending k, one word per y handshake.
REQ-014 SHALL transfer a word on any interface only in a cycle where valid and ready are both 1 at the rising edge.
REQ-015 SHALL use states WLOAD, XLOAD, COMPUTE, DRAIN.
REQ-016 WLOAD: w_ready=1, x_ready=0; the first accepted weight is f[0]; after M accepted weights -> XLOAD.
REQ-017 XLOAD: x_ready=1 while fewer than N words are held; after the N-th accepted word -> COMPUTE.
REQ-018 XLOAD with zero x words accepted and w_valid=1: -> WLOAD (weight reload); w_valid takes priority over a simultaneous x_valid, and no x word is consumed that cycle.
REQ-019 w_ready SHALL be 0 outside WLOAD; weights SHALL hold unchanged across vectors until reloaded.
REQ-020 COMPUTE: P lanes each accumulate one output over M cycles, plus 1 pipeline cycle, then load a P-entry output buffer -> DRAIN.
REQ-021 DRAIN: y_valid=1 while the buffer is non-empty; y_data and y_valid SHALL hold stable until y_ready.
REQ-022 DRAIN with the buffer emptied: -> COMPUTE if outputs remain for this vector, else -> XLOAD.
REQ-023 x_ready SHALL be 0 from the N-th x accept until the last y of that vector is accepted (no overlap).
REQ-024 Products SHALL be full 2T bits and the accumulator 2T+clog2(M) bits; no intermediate truncation.
REQ-025 The final result SHALL saturate to [-2^(T-1), 2^(T-1)-1].

Reset
REQ-026 reset SHALL asynchronously force state WLOAD, all counters 0, and the output buffer empty.
REQ-027 During and after reset: w_ready=1, x_ready=0, y_valid=0, y_data=0.
REQ-028 Reset mid-operation SHALL discard the partial vector, pending outputs and weights; weights SHALL be reloaded before the next vector.

Configuration
REQ-029 With CONV_RELU_EN defined, negative saturated results SHALL be output as 0.
REQ-030 Without CONV_RELU_EN, the saturated signed result SHALL be output unchanged.

Structure
REQ-031 Package conv_pkg SHALL hold the state enum typedef and a saturation function parametrised by input and output widths.
REQ-032 Sub-module conv_mac (one multiply-accumulate lane with clear and enable) SHALL be instantiated P times.

Verification
REQ-033 Weights 1,2,3,4; x=0..15 -> y[0]=20, y[12]=140, exactly 13 outputs.
REQ-034 Weights all 0x7FFFF; x all 0x7FFFF -> every y=0x7FFFF (positive saturation).
REQ-035 Weights all 0x7FFFF; x all 0x80000 -> every y=0x80000; with CONV_RELU_EN every y=0.
REQ-036 Vector 1 with weights 1,0,0,0, then reload weights 0,0,0,1, then vector 2 with x=0..15 -> vector 1 y[k]=x[k]; vector 2 y[k]=k+3.
REQ-037 Hold y_ready=0 for 50 cycles mid-vector -> y_data/y_valid stable, x_ready=0, no output lost or duplicated.
REQ-038 Assert reset during COMPUTE -> y_valid=0 and w_ready=1 immediately; after reloading weights 1,2,3,4 and x=0..15, the REQ-033 results repeat; random valid/ready gaps with P=13 give identical results.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: state encoding and width-parametrised saturation shared by conv_param
package conv_pkg;

    typedef enum logic [1:0] {WLOAD, XLOAD, COMPUTE, DRAIN} state_t;

    localparam int SAT_MAXW = 128;

    function automatic logic signed [SAT_MAXW-1:0] sat(
        input logic signed [SAT_MAXW-1:0] v,
        input int in_w,
        input int out_w
    );
        logic signed [SAT_MAXW-1:0] ve, hi, lo;
        ve = (v <<< (SAT_MAXW - in_w)) >>> (SAT_MAXW - in_w);
        hi = (SAT_MAXW'(1) <<< (out_w - 1)) - SAT_MAXW'(1);
        lo = ~hi;
        return (ve > hi) ? hi : ((ve < lo) ? lo : ve);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: one signed multiply-accumulate lane; clr restarts the sum, en advances it
module conv_mac #(
    parameter int T  = 20,
    parameter int AW = 42
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [T-1:0]  a,
    input  logic [T-1:0]  b,
    output logic [AW-1:0] acc
);

    logic signed [2*T-1:0] prod;
    logic signed [AW-1:0]  prod_x;
    logic signed [AW-1:0]  acc_d;
    logic signed [AW-1:0]  acc_q;

    // full-width product sign-extended into the accumulator; no truncation anywhere
    always_comb begin
        prod   = (2*T)'($signed(a)) * (2*T)'($signed(b));
        prod_x = AW'(prod);
        acc_d  = en ? (clr ? '0 : acc_q) + prod_x : acc_q;
    end

    // accumulator register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv_param.sv
// conv_param: valid/ready M-tap convolution of an N-word vector using P MAC lanes
// Build macro CONV_RELU_EN: negative saturated results are output as 0.
module conv_param
    import conv_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 20,
    parameter int P = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic [T-1:0] w_data,
    input  logic         w_valid,
    output logic         w_ready,
    output logic [T-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready
);

    localparam int AW = 2*T + $clog2(M);
    localparam int CW = $clog2(N + 1);
    localparam int XW = $clog2(N);
    localparam int MW = $clog2(M);

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d, xcnt_q, xcnt_d, k_q, k_d, j_q, j_d, left_q, left_d;
    logic [T-1:0]  f_q [M];
    logic [T-1:0]  f_d [M];
    logic [T-1:0]  x_q [N];
    logic [T-1:0]  x_d [N];
    logic [T-1:0]  ybuf_q [P];
    logic [T-1:0]  ybuf_d [P];
    logic [T-1:0]  res [P];
    logic [AW-1:0] acc [P];
    logic [MW-1:0] tap;
    logic          lane_en, lane_clr, w_fire, x_fire, y_fire;

    assign w_ready  = state_q == WLOAD;
    assign x_ready  = state_q == XLOAD && !(xcnt_q == '0 && w_valid);
    assign y_valid  = state_q == DRAIN;
    assign y_data   = y_valid ? ybuf_q[0] : '0;
    assign w_fire   = w_valid && w_ready;
    assign x_fire   = x_valid && x_ready;
    assign y_fire   = y_valid && y_ready;
    assign lane_en  = state_q == COMPUTE && j_q < CW'(M);
    assign lane_clr = j_q == '0;
    assign tap      = lane_en ? MW'(j_q) : '0;

    for (genvar i = 0; i < P; i++) begin : g_lane
        logic [XW-1:0] xi;
        logic [T-1:0]  sat_v;
        assign xi    = XW'(int'(k_q) + i + int'(tap));
        assign sat_v = T'(sat(SAT_MAXW'($signed(acc[i])), AW, T));
        conv_mac #(.T(T), .AW(AW)) u_mac (
            .clk   (clk),
            .reset (reset),
            .clr   (lane_clr),
            .en    (lane_en),
            .a     (x_q[xi]),
            .b     (f_q[tap]),
            .acc   (acc[i])
        );
`ifdef CONV_RELU_EN
        assign res[i] = sat_v[T-1] ? '0 : sat_v;
`else
        assign res[i] = sat_v;
`endif
    end

    // next-state: weight/vector shift-in, lane sequencing and output buffer drain
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        xcnt_d  = xcnt_q;
        k_d     = k_q;
        j_d     = j_q;
        left_d  = left_q;
        f_d     = f_q;
        x_d     = x_q;
        ybuf_d  = ybuf_q;
        if (state_q == WLOAD) begin
            if (w_fire) begin
                for (int i = 0; i < M-1; i++) f_d[i] = f_q[i+1];
                f_d[M-1] = w_data;
                wcnt_d   = wcnt_q + CW'(1);
                if (wcnt_q == CW'(M-1)) begin
                    state_d = XLOAD;
                    xcnt_d  = '0;
                end
            end
        end else if (state_q == XLOAD) begin
            if (x_fire) begin
                for (int i = 0; i < N-1; i++) x_d[i] = x_q[i+1];
                x_d[N-1] = x_data;
                xcnt_d   = xcnt_q + CW'(1);
                if (xcnt_q == CW'(N-1)) begin
                    state_d = COMPUTE;
                    k_d     = '0;
                    j_d     = '0;
                end
            end else if (xcnt_q == '0 && w_valid) begin
                state_d = WLOAD;
                wcnt_d  = '0;
            end
        end else if (state_q == COMPUTE) begin
            if (j_q == CW'(M)) begin
                ybuf_d  = res;
                left_d  = CW'(P);
                j_d     = '0;
                state_d = DRAIN;
            end else begin
                j_d = j_q + CW'(1);
            end
        end else if (y_fire) begin
            for (int i = 0; i < P-1; i++) ybuf_d[i] = ybuf_q[i+1];
            left_d = left_q - CW'(1);
            if (left_q == CW'(1)) begin
                if (int'(k_q) + P <= N - M) begin
                    state_d = COMPUTE;
                    k_d     = k_q + CW'(P);
                end else begin
                    state_d = XLOAD;
                    xcnt_d  = '0;
                end
            end
        end
    end

    // state registers; reset discards weights, vector and pending outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WLOAD;
            wcnt_q  <= '0;
            xcnt_q  <= '0;
            k_q     <= '0;
            j_q     <= '0;
            left_q  <= '0;
            f_q     <= '{default: '0};
            x_q     <= '{default: '0};
            ybuf_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            xcnt_q  <= xcnt_d;
            k_q     <= k_d;
            j_q     <= j_d;
            left_q  <= left_d;
            f_q     <= f_d;
            x_q     <= x_d;
            ybuf_q  <= ybuf_d;
        end
    end

endmodule

// File: tb/tb_conv_param.sv
// tb_conv_param: scoreboard bench for conv_param with one P=1 and one P=13 instance
module tb_conv_param;

    localparam int N  = 16;
    localparam int M  = 4;
    localparam int T  = 20;
    localparam int NO = N - M + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [T-1:0] xd [2];
    logic [T-1:0] wd [2];
    logic [T-1:0] yd [2];
    logic         xv [2];
    logic         xr [2];
    logic         wv [2];
    logic         wr [2];
    logic         yv [2];
    logic         yr [2];
    logic [T-1:0] wcur [2][M];
    logic [T-1:0] sb [$];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    conv_param #(.N(N), .M(M), .T(T), .P(1)) dut0 (
        .clk(clk), .reset(reset),
        .x_data(xd[0]), .x_valid(xv[0]), .x_ready(xr[0]),
        .w_data(wd[0]), .w_valid(wv[0]), .w_ready(wr[0]),
        .y_data(yd[0]), .y_valid(yv[0]), .y_ready(yr[0])
    );

    conv_param #(.N(N), .M(M), .T(T), .P(13)) dut1 (
        .clk(clk), .reset(reset),
        .x_data(xd[1]), .x_valid(xv[1]), .x_ready(xr[1]),
        .w_data(wd[1]), .w_valid(wv[1]), .w_ready(wr[1]),
        .y_data(yd[1]), .y_valid(yv[1]), .y_ready(yr[1])
    );

    function automatic logic [T-1:0] ref_y(input logic [T-1:0] xa [N], input logic [T-1:0] fa [M], input int k);
        longint s = 0;
        for (int j = 0; j < M; j++) s += longint'($signed(xa[k+j])) * longint'($signed(fa[j]));
        if (s > 524287) s = 524287;
        if (s < -524288) s = -524288;
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[T-1:0];
    endfunction

    task automatic load_weights(input int d, input logic [T-1:0] w [M], input int gap);
        int i = 0;
        int cyc = 0;
        while (i < M && cyc < 500) begin
            @(posedge clk); #1;
            wd[d] = w[i];
            wv[d] = $urandom_range(99) >= gap;
            @(negedge clk);
            if (wv[d] && wr[d]) i++;
            cyc++;
        end
        @(posedge clk); #1;
        wv[d] = 1'b0;
        checks++;
        if (i != M) begin
            errors++;
            $display("FAIL load_weights dut%0d: accepted %0d weights, required %0d", d, i, M);
        end
        wcur[d] = w;
    endtask

    task automatic run_vector(input int d, input logic [T-1:0] xa [N], input int gap, input int stall_at, input string name);
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int stall = 0;
        logic stalling;
        logic seen = 1'b0;
        logic [T-1:0] held = '0;
        logic [T-1:0] e;
        for (int k = 0; k < NO; k++) sb.push_back(ref_y(xa, wcur[d], k));
        while ((idx < N || got < NO) && cyc < 4000) begin
            @(posedge clk); #1;
            xd[d] = xa[(idx < N) ? idx : 0];
            xv[d] = idx < N && $urandom_range(99) >= gap;
            stalling = got == stall_at && stall < 50;
            if (stalling) begin
                yr[d] = 1'b0;
                stall++;
            end else begin
                yr[d] = $urandom_range(99) >= gap;
            end
            @(negedge clk);
            if (stalling) begin
                if (!seen && yv[d]) begin
                    seen = 1'b1;
                    held = yd[d];
                end else if (seen) begin
                    checks++;
                    if (yv[d] !== 1'b1 || yd[d] !== held) begin
                        errors++;
                        $display("FAIL %s stall hold: y_valid=%b y_data=%h, required 1/%h", name, yv[d], yd[d], held);
                    end
                end
            end
            if (idx == N) begin
                checks++;
                if (xr[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s x_ready during output: got %b want 0", name, xr[d]);
                end
            end
            if (xv[d] && xr[d]) idx++;
            if (yv[d] && yr[d]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra output: got %h, none expected", name, yd[d]);
                end else begin
                    e = sb.pop_front();
                    if (yd[d] !== e) begin
                        errors++;
                        $display("FAIL %s y[%0d]: got %h want %h", name, got, yd[d], e);
                    end
                end
                got++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        xv[d] = 1'b0;
        yr[d] = 1'b0;
        @(negedge clk);
        checks++;
        if (got != NO || idx != N) begin
            errors++;
            $display("FAIL %s completion: x accepted %0d y received %0d, required %0d/%0d", name, idx, got, N, NO);
        end
        checks++;
        if (yv[d] !== 1'b0 || xr[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s end state: y_valid=%b x_ready=%b, required 0/1", name, yv[d], xr[d]);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wr[d] !== 1'b1 || xr[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset ready dut%0d: w_ready=%b x_ready=%b, required 1/0", d, wr[d], xr[d]);
            end
            checks++;
            if (yv[d] !== 1'b0 || yd[d] !== '0) begin
                errors++;
                $display("FAIL reset output dut%0d: y_valid=%b y_data=%h, required 0/0", d, yv[d], yd[d]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wr[d] !== 1'b1 || xr[d] !== 1'b0 || yv[d] !== 1'b0) begin
                errors++;
                $display("FAIL post-reset dut%0d: w_ready=%b x_ready=%b y_valid=%b, required 1/0/0", d, wr[d], xr[d], yv[d]);
            end
        end
    endtask

    task automatic test_basic(input logic [T-1:0] ramp [N]);
        logic [T-1:0] w [M];
        for (int i = 0; i < M; i++) w[i] = T'(i + 1);
        load_weights(0, w, 0);
        run_vector(0, ramp, 0, -1, "basic");
    endtask

    task automatic test_saturation();
        logic [T-1:0] w [M];
        logic [T-1:0] xa [N];
        for (int i = 0; i < M; i++) w[i] = 20'h7FFFF;
        for (int i = 0; i < N; i++) xa[i] = 20'h7FFFF;
        load_weights(0, w, 0);
        run_vector(0, xa, 0, -1, "sat_pos");
        for (int i = 0; i < N; i++) xa[i] = 20'h80000;
        run_vector(0, xa, 0, -1, "sat_neg");
    endtask

    task automatic test_reload(input logic [T-1:0] ramp [N]);
        logic [T-1:0] w [M];
        logic [T-1:0] xa [N];
        for (int i = 0; i < M; i++) w[i] = (i == 0) ? T'(1) : T'(0);
        for (int i = 0; i < N; i++) xa[i] = T'($urandom);
        load_weights(0, w, 0);
        run_vector(0, xa, 0, -1, "reload_v1");
        @(posedge clk); #1;
        wd[0] = '0;
        wv[0] = 1'b1;
        xd[0] = 20'h12345;
        xv[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (xr[0] !== 1'b0 || wr[0] !== 1'b0) begin
            errors++;
            $display("FAIL reload priority: x_ready=%b w_ready=%b, required 0/0", xr[0], wr[0]);
        end
        @(posedge clk); #1;
        wv[0] = 1'b0;
        xv[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (wr[0] !== 1'b1 || xr[0] !== 1'b0) begin
            errors++;
            $display("FAIL reload enter: w_ready=%b x_ready=%b, required 1/0", wr[0], xr[0]);
        end
        for (int i = 0; i < M; i++) w[i] = (i == M-1) ? T'(1) : T'(0);
        load_weights(0, w, 0);
        run_vector(0, ramp, 0, -1, "reload_v2");
    endtask

    task automatic test_back_to_back();
        logic [T-1:0] w [M];
        logic [T-1:0] xa [N];
        for (int i = 0; i < M; i++) w[i] = T'($urandom_range(2000)) - T'(1000);
        load_weights(0, w, 0);
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < N; i++) xa[i] = T'($urandom_range(4000)) - T'(2000);
            run_vector(0, xa, 0, -1, "back_to_back");
        end
    endtask

    task automatic test_stall();
        logic [T-1:0] xa [N];
        for (int i = 0; i < N; i++) xa[i] = T'($urandom_range(4000)) - T'(2000);
        run_vector(0, xa, 0, 5, "stall");
    endtask

    task automatic test_reset_mid(input logic [T-1:0] ramp [N]);
        logic [T-1:0] w [M];
        int idx = 0;
        int cyc = 0;
        for (int i = 0; i < M; i++) w[i] = T'(i + 1);
        load_weights(0, w, 0);
        while (idx < N && cyc < 200) begin
            @(posedge clk); #1;
            xd[0] = ramp[idx];
            xv[0] = 1'b1;
            @(negedge clk);
            if (xv[0] && xr[0]) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        xv[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (yv[0] !== 1'b0 || wr[0] !== 1'b1 || xr[0] !== 1'b0 || yd[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid: y_valid=%b w_ready=%b x_ready=%b y_data=%h, required 0/1/0/0", yv[0], wr[0], xr[0], yd[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        xv[0] = 1'b1;
        xd[0] = 20'h00055;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (xr[0] !== 1'b0 || yv[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid no weights: x_ready=%b y_valid=%b, required 0/0", xr[0], yv[0]);
            end
        end
        @(posedge clk); #1;
        xv[0] = 1'b0;
        load_weights(0, w, 0);
        run_vector(0, ramp, 0, -1, "reset_mid_rerun");
    endtask

    task automatic test_random_p13(input logic [T-1:0] ramp [N]);
        logic [T-1:0] w [M];
        logic [T-1:0] xa [N];
        for (int i = 0; i < M; i++) w[i] = T'(i + 1);
        load_weights(1, w, 30);
        run_vector(1, ramp, 30, -1, "p13_ramp");
        for (int i = 0; i < M; i++) w[i] = T'($urandom);
        for (int i = 0; i < N; i++) xa[i] = T'($urandom);
        load_weights(1, w, 40);
        run_vector(1, xa, 40, -1, "p13_random");
        run_vector(1, xa, 0, 4, "p13_stall");
    endtask

    initial begin
        logic [T-1:0] ramp [N];
        for (int i = 0; i < N; i++) ramp[i] = T'(i);
        for (int d = 0; d < 2; d++) begin
            xd[d] = '0;
            wd[d] = '0;
            xv[d] = 1'b0;
            wv[d] = 1'b0;
            yr[d] = 1'b0;
        end
        test_reset();
        test_basic(ramp);
        test_saturation();
        test_reload(ramp);
        test_back_to_back();
        test_stall();
        test_reset_mid(ramp);
        test_random_p13(ramp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
